reg_file_32x32: RTL and testbench
=================================

REG_FILE_32X32 -- requirements
Module: reg_file_32x32

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register word width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (2**ADDR_W entries).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ra_addr  input  ADDR_W  read port A index (rs field).
REQ-006 SHALL have port rb_addr  input  ADDR_W  read port B index (rt field).
REQ-007 SHALL have port ra_data  output  DATA_W  read port A data.
REQ-008 SHALL have port rb_data  output  DATA_W  read port B data.
REQ-009 SHALL have port we  input  1  write enable.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write index, driven by the upstream 5-bit destination select.
REQ-011 SHALL have port wr_data  input  DATA_W  write data, driven by the upstream 32-bit writeback select.
REQ-012 SHALL have port wr_count  output  16  count of committed writes, for debug.

Function
REQ-013 SHALL hold 2**ADDR_W registers; entry 0 SHALL read as zero always.
REQ-014 SHALL commit wr_data to entry wr_addr on a rising clk edge when we=1 and wr_addr!=0.
REQ-015 SHALL discard writes to entry 0 with no state change and no wr_count increment.
REQ-016 SHALL leave all entries unchanged on edges where we=0.
REQ-017 SHALL drive ra_data and rb_data combinationally from ra_addr and rb_addr, with zero cycles of address-to-data latency.
REQ-018 SHALL return the pre-edge value when a port reads the entry being written in the same cycle, unless REGFILE_BYPASS_EN is defined (see REQ-027).
REQ-019 SHALL allow ra_addr==rb_addr; both ports then return identical data.
REQ-020 SHALL increment wr_count by 1 per committed write and wrap from 16'hFFFF to 0 without saturating.
REQ-021 SHALL treat X or Z on we as no write; simulation assertion flags it.

Reset
REQ-022 SHALL, on rst_n low, immediately clear every entry and wr_count to 0, independent of clk.
REQ-023 SHALL drive ra_data and rb_data to 0 while rst_n is low.
REQ-024 SHALL ignore we while rst_n is low; a write coincident with reset assertion is lost.
REQ-025 SHALL accept the first write on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro REGFILE_BYPASS_EN to select write-to-read forwarding.
REQ-027 SHALL, when REGFILE_BYPASS_EN is defined, return wr_data on a read port whose address equals wr_addr while we=1 and wr_addr!=0 (same-cycle forwarding).
REQ-028 SHALL, when REGFILE_BYPASS_EN is undefined, have no forwarding path; reads return stored contents only.

Structure
REQ-029 SHALL take DATA_W, ADDR_W and the constant REG_ZERO=0 from the shared CPU package, which also defines the type reg_idx_t.
REQ-030 SHALL place read-port logic (zero-index check plus optional forwarding) in one sub-module, reg_file_rd_port, instantiated twice.
REQ-031 SHALL contain no other sub-modules; storage is a flat array in the top module.

Verification
REQ-032 Reset: assert rst_n=0 mid-cycle after writing 0x1234 to entry 5 -> ra_addr=5 reads 0 immediately, and wr_count=0.
REQ-033 Write/read: we=1, wr_addr=8, wr_data=0xDEADBEEF, one edge -> ra_addr=8 and rb_addr=8 both read 0xDEADBEEF, and wr_count=1.
REQ-034 Zero entry: we=1, wr_addr=0, wr_data=0xFFFFFFFF -> ra_addr=0 reads 0, and wr_count is unchanged.
REQ-035 Same-cycle hazard: entry 3 holds 0x11; drive we=1, wr_addr=3, wr_data=0x22, ra_addr=3 before the edge -> ra_data reads 0x22 with REGFILE_BYPASS_EN defined, 0x11 without it; after the edge it reads 0x22 in both builds.
REQ-036 Hold: we=0 for 10 cycles with random wr_addr and wr_data -> all 32 entries unchanged.
REQ-037 Counter wrap: 65536 committed writes -> wr_count returns to 0.

Source files
------------

// File: rtl/reg_file_32x32_pkg.sv
// rtl/reg_file_32x32_pkg.sv - shared CPU constants and register index type for the register file
package reg_file_32x32_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_32x32_rd_port.sv
// rtl/reg_file_32x32_rd_port.sv - read port: zero-index masking, reset masking, optional forwarding
// REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module reg_file_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
`ifdef REGFILE_BYPASS_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    import reg_file_32x32_pkg::*;

    always_comb begin
        rd_data = stored_data;
`ifdef REGFILE_BYPASS_EN
        if ((we == 1'b1) && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
`else
        rd_data = stored_data;
`endif
        // The zero-index mask also blocks forwarding of a discarded write to entry 0.
        if (!rst_n || (rd_addr == ADDR_W'(REG_ZERO))) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - 2**ADDR_W x DATA_W register file, two combinational read ports, one write port
// REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding on both read ports.
module reg_file_32x32 #(
    parameter int DATA_W = reg_file_32x32_pkg::DATA_W,
    parameter int ADDR_W = reg_file_32x32_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       wr_count
);

    import reg_file_32x32_pkg::*;

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit;

    // An unknown we fails the equality test, so it never commits.
    assign wr_commit = (we == 1'b1) && (wr_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
            wr_count      <= wr_count + 16'd1;
        end
    end

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
        .rst_n       (rst_n),
        .rd_addr     (ra_addr),
        .stored_data (regs[ra_addr]),
`ifdef REGFILE_BYPASS_EN
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`endif
        .rd_data     (ra_data)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
        .rst_n       (rst_n),
        .rd_addr     (rb_addr),
        .stored_data (regs[rb_addr]),
`ifdef REGFILE_BYPASS_EN
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`endif
        .rd_data     (rb_data)
    );

    we_known_a: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(we))
        else $error("we is X or Z at clock edge");

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb/tb_reg_file_32x32.sv - self-checking bench for reg_file_32x32 (directed table, hazards, random, wrap)
module tb_reg_file_32x32;

    import reg_file_32x32_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    reg_idx_t          ra_addr, rb_addr, wr_addr;
    logic [31:0]       ra_data, rb_data, wr_data;
    logic              we;
    logic [15:0]       wr_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];
    logic [15:0] mdl_count;

    typedef struct {
        logic        we;
        int          wa;
        logic [31:0] wd;
        int          ra;
        int          rb;
        logic [31:0] exp_ra;
        logic [31:0] exp_rb;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [6];

    reg_file_32x32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl_count = '0;
    endfunction

    // Expected combinational read given the current (pre-edge) write inputs.
    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && (int'(wr_addr) == a)) return wr_data;
`endif
        return mdl[a];
    endfunction

    // Apply write inputs, take one rising edge, update the model, return at posedge+1.
    task automatic cycle(input logic w, input int wa, input logic [31:0] wd);
        we      = w;
        wr_addr = reg_idx_t'(wa);
        wr_data = wd;
        @(posedge clk);
        if (w && wa != 0) begin
            mdl[wa]   = wd;
            mdl_count = mdl_count + 16'd1;
        end
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8,  32'hDEADBEEF, 8,  8,  32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[1] = '{1'b1, 0,  32'hFFFFFFFF, 0,  8,  32'h0,        32'hDEADBEEF, 16'd1};
        vecs[2] = '{1'b1, 3,  32'h00000011, 3,  0,  32'h11,       32'h0,        16'd2};
        vecs[3] = '{1'b0, 3,  32'h00000099, 3,  8,  32'h11,       32'hDEADBEEF, 16'd2};
        vecs[4] = '{1'b1, 31, 32'hA5A5A5A5, 31, 3,  32'hA5A5A5A5, 32'h11,       16'd3};
        vecs[5] = '{1'b1, 31, 32'h0000005A, 31, 31, 32'h5A,       32'h5A,       16'd4};

        rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; ra_addr = 5'd7; rb_addr = 5'd9;
        model_clear();
        #12;
        check("reset_ra", ra_data, 32'h0);
        check("reset_rb", rb_data, 32'h0);
        check("reset_cnt", {16'h0, wr_count}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Directed table; first entry also lands on the first edge after reset release.
        for (int i = 0; i < 6; i++) begin
            ra_addr = reg_idx_t'(vecs[i].ra);
            rb_addr = reg_idx_t'(vecs[i].rb);
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd);
            we = 1'b0;
            #1;
            check($sformatf("vec%0d_ra", i), ra_data, vecs[i].exp_ra);
            check($sformatf("vec%0d_rb", i), rb_data, vecs[i].exp_rb);
            check($sformatf("vec%0d_cnt", i), {16'h0, wr_count}, {16'h0, vecs[i].exp_cnt});
        end

        // Same-cycle hazard on entry 3 (holds 0x11).
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h22; ra_addr = 5'd3; rb_addr = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre", ra_data, 32'h22);
`else
        check("hazard_pre", ra_data, 32'h11);
`endif
        check("hazard_rb_zero", rb_data, 32'h0);
        cycle(1'b1, 3, 32'h22);
        we = 1'b0;
        #1;
        check("hazard_post", ra_data, 32'h22);

        // Hold: random addresses and data with we low.
        for (int i = 0; i < 10; i++) cycle(1'b0, $urandom_range(0, 31), $urandom);
        for (int a = 0; a < 32; a++) begin
            ra_addr = reg_idx_t'(a);
            rb_addr = reg_idx_t'(31 - a);
            #1;
            check($sformatf("hold_ra%0d", a), ra_data, mdl[a]);
            check($sformatf("hold_rb%0d", 31 - a), rb_data, mdl[31 - a]);
        end
        check("hold_cnt", {16'h0, wr_count}, {16'h0, mdl_count});

        // Random traffic checked against the model before each edge.
        for (int i = 0; i < 300; i++) begin
            int wa;
            logic w;
            logic [31:0] wd;
            w  = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 31);
            wd = $urandom;
            we = w; wr_addr = reg_idx_t'(wa); wr_data = wd;
            ra_addr = ($urandom_range(0, 2) == 0) ? reg_idx_t'(wa) : reg_idx_t'($urandom_range(0, 31));
            rb_addr = ($urandom_range(0, 3) == 0) ? ra_addr : reg_idx_t'($urandom_range(0, 31));
            #1;
            check("rand_ra", ra_data, exp_read(int'(ra_addr)));
            check("rand_rb", rb_data, exp_read(int'(rb_addr)));
            check("rand_cnt", {16'h0, wr_count}, {16'h0, mdl_count});
            cycle(w, wa, wd);
        end

        // Mid-cycle asynchronous reset after writing entry 5.
        ra_addr = 5'd5; rb_addr = 5'd5;
        cycle(1'b1, 5, 32'h1234);
        we = 1'b0;
        #1;
        check("pre_rst_ra5", ra_data, 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ra5", ra_data, 32'h0);
        check("async_rst_cnt", {16'h0, wr_count}, 32'h0);
        model_clear();
        cycle(1'b1, 5, 32'hCAFE0000);
        model_clear();
        we = 1'b0;
        check("rst_write_lost_cnt", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_write_lost_ra5", ra_data, 32'h0);

        // Counter wrap after 65536 committed writes.
        for (int i = 0; i < 65535; i++) cycle(1'b1, (i % 31) + 1, i);
        check("cnt_ffff", {16'h0, wr_count}, 32'h0000FFFF);
        cycle(1'b1, 0, 32'h1);
        check("cnt_zero_write_no_inc", {16'h0, wr_count}, 32'h0000FFFF);
        cycle(1'b1, 1, 32'h1);
        we = 1'b0;
        #1;
        check("cnt_wrap", {16'h0, wr_count}, 32'h0);
        check("cnt_wrap_model", {16'h0, wr_count}, {16'h0, mdl_count});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
